// File: rtl/corescore_stream_arbiter.sv
// rtl/corescore_stream_arbiter.sv - packet-level round-robin arbiter for byte streams
// Forwards whole packets from one of N sources into a single registered output stream.
module corescore_stream_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [8*N-1:0]  i_tdata,
  input  logic [N-1:0]    i_tlast,
  input  logic [N-1:0]    i_tvalid,
  output logic [N-1:0]    o_tready,
  output logic [7:0]      o_tdata,
  output logic            o_tlast,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [IW-1:0]   o_grant,
  output logic            o_busy
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    tdata_q;
  logic          tlast_q;
  logic          tvalid_q;

  logic          slot_ready;
  logic          accept;
  logic [IW-1:0] pick;
  logic          pick_found;
  logic [IW-1:0] cand_idx;
  int            cand;

  // The grantee may push whenever the output register is empty or draining.
  assign slot_ready = ~tvalid_q | i_tready;
  assign accept     = (state_q == S_GRANT) & i_tvalid[grant_q] & slot_ready;

  // Search starts just after the last grantee, so it ends up lowest priority.
  always_comb begin
    pick       = grant_q;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(grant_q) + k) % N;
      cand_idx = IW'(cand);
      if (!pick_found && i_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick       = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept && i_tlast[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_tready = '0;
    if (state_q == S_GRANT) begin
      o_tready[grant_q] = slot_ready;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (accept) begin
      tdata_q  <= i_tdata[{grant_q, 3'b000} +: 8];
      tlast_q  <= i_tlast[grant_q];
      tvalid_q <= 1'b1;
    end else if (i_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_grant  = grant_q;
  assign o_busy   = (state_q == S_GRANT);

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// tb/tb_corescore_stream_arbiter.sv - self-checking bench for corescore_stream_arbiter
// Cycle table for the basic paths, then hand-written and randomised sequences.
module tb_corescore_stream_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [8*N-1:0] i_tdata = '0;
  logic [N-1:0]  i_tlast = '0;
  logic [N-1:0]  i_tvalid = '0;
  logic [N-1:0]  o_tready;
  logic [7:0]    o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          i_tready = 1'b1;
  logic [1:0]    o_grant;
  logic          o_busy;

  corescore_stream_arbiter #(.N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_trdy;
    logic        e_tv;
    logic [7:0]  e_td;
    logic        e_tl;
    logic [1:0]  e_gr;
    logic        e_busy;
  } vec_t;

  vec_t tbl [15];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_tvalid = '0;
    i_tlast = '0;
    i_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // random-phase state
  logic [3:0] vld_r;
  int         rem [4];
  logic [5:0] seq [4];
  logic [5:0] exp_seq [4];
  int         waitc [4];
  logic       in_pkt;
  logic [1:0] cur_src;

  task automatic rand_cycle(input bit allow_new);
    logic       arb;
    logic [3:0] tv, hs;
    logic [1:0] src;
    for (int k = 0; k < 4; k++) begin
      if (!vld_r[k]) begin
        if (rem[k] == 0 && allow_new && $urandom_range(3) == 0) rem[k] = $urandom_range(4, 1);
        if (rem[k] > 0 && $urandom_range(2) != 0) vld_r[k] = 1'b1;
      end
      i_tdata[8*k +: 8] = {2'(k), seq[k]};
      i_tlast[k] = (rem[k] == 1);
    end
    i_tvalid = vld_r;
    i_tready = allow_new ? ($urandom_range(3) != 0) : 1'b1;
    #1;
    arb = !o_busy && (|i_tvalid);
    tv  = i_tvalid;
    hs  = i_tvalid & o_tready;
    if (o_tvalid && i_tready) begin
      src = o_tdata[7:6];
      chk("rand_seq", {26'd0, o_tdata[5:0]}, {26'd0, exp_seq[src]});
      exp_seq[src] = exp_seq[src] + 6'd1;
      if (in_pkt) chk("rand_interleave", {30'd0, src}, {30'd0, cur_src});
      in_pkt  = !o_tlast;
      cur_src = src;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (hs[k]) begin
        seq[k] = seq[k] + 6'd1;
        rem[k] = rem[k] - 1;
        vld_r[k] = 1'b0;
      end
    end
    if (arb) begin
      for (int j = 0; j < 4; j++) begin
        if (j == int'(o_grant)) waitc[j] = 0;
        else if (tv[j]) begin
          waitc[j]++;
          chk("rand_fair_wait", {31'd0, waitc[j] <= 3}, 32'd1);
        end else waitc[j] = 0;
      end
    end
  endtask

  initial begin
    int         nout, last_cyc, idx0, idx2, dropc;
    logic [3:0] b, hs;
    logic       done, done3, drop;
    logic [7:0] exp4 [4];
    int         src;

    tbl[0]  = '{4'h1, 4'h0, 32'h0000_0041, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 32'h0000_0041, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{4'h1, 4'h0, 32'h0000_0042, 1'b1, 4'h1, 1'b1, 8'h41, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{4'h1, 4'h1, 32'h0000_0043, 1'b1, 4'h1, 1'b1, 8'h42, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b1, 8'h43, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{4'h2, 4'h0, 32'h0000_5800, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'h2, 4'h0, 32'h0000_5800, 1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1};
    tbl[8]  = '{4'h2, 4'h2, 32'h0000_5900, 1'b0, 4'h0, 1'b1, 8'h58, 1'b0, 2'd1, 1'b1};
    tbl[9]  = '{4'h2, 4'h2, 32'h0000_5900, 1'b0, 4'h0, 1'b1, 8'h58, 1'b0, 2'd1, 1'b1};
    tbl[10] = '{4'h2, 4'h2, 32'h0000_5900, 1'b0, 4'h0, 1'b1, 8'h58, 1'b0, 2'd1, 1'b1};
    tbl[11] = '{4'h2, 4'h2, 32'h0000_5900, 1'b0, 4'h0, 1'b1, 8'h58, 1'b0, 2'd1, 1'b1};
    tbl[12] = '{4'h2, 4'h2, 32'h0000_5900, 1'b1, 4'h2, 1'b1, 8'h58, 1'b0, 2'd1, 1'b1};
    tbl[13] = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b1, 8'h59, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};

    // reset state, with all sources requesting to show no grant leaks through
    rst = 1'b1;
    i_tvalid = 4'hF;
    #12;
    chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, o_tdata}, 32'd0);
    chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
    chk("rst_grant", {30'd0, o_grant}, 32'd3);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_tready", {28'd0, o_tready}, 32'd0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      i_tvalid = tbl[i].vld;
      i_tlast  = tbl[i].last;
      i_tdata  = tbl[i].data;
      i_tready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_tready", i), {28'd0, o_tready}, {28'd0, tbl[i].e_trdy});
      chk($sformatf("tbl%0d_tvalid", i), {31'd0, o_tvalid}, {31'd0, tbl[i].e_tv});
      chk($sformatf("tbl%0d_grant", i), {30'd0, o_grant}, {30'd0, tbl[i].e_gr});
      chk($sformatf("tbl%0d_busy", i), {31'd0, o_busy}, {31'd0, tbl[i].e_busy});
      if (tbl[i].e_tv) begin
        chk($sformatf("tbl%0d_tdata", i), {24'd0, o_tdata}, {24'd0, tbl[i].e_td});
        chk($sformatf("tbl%0d_tlast", i), {31'd0, o_tlast}, {31'd0, tbl[i].e_tl});
      end
      @(negedge clk);
    end

    // all four sources streaming 2-beat packets: strict order, one idle cycle between
    do_reset();
    b = '0; nout = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 100 && nout < 16; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        i_tdata[8*k +: 8] = b[k] ? 8'(16 + k) : 8'(k);
        i_tlast[k] = b[k];
      end
      i_tvalid = 4'hF;
      #1;
      hs = i_tvalid & o_tready;
      if (o_tvalid) begin
        src = (nout / 2) % 4;
        chk("rr_data", {24'd0, o_tdata}, (nout % 2 == 1) ? 32'(16 + src) : 32'(src));
        chk("rr_last", {31'd0, o_tlast}, 32'(nout % 2));
        if (nout > 0) chk("rr_gap", 32'(cyc - last_cyc), (nout % 2 == 1) ? 32'd1 : 32'd2);
        last_cyc = cyc;
        nout++;
      end
      @(negedge clk);
      b = b ^ hs;
    end
    chk("rr_count", 32'(nout), 32'd16);
    i_tvalid = '0;

    // grantee 2 stalls 5 cycles mid-packet while source 3 waits
    do_reset();
    exp4[0] = 8'h20; exp4[1] = 8'h21; exp4[2] = 8'h22; exp4[3] = 8'h30;
    idx2 = 0; done3 = 1'b0; dropc = 0; nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
      drop = (idx2 == 1) && (dropc < 5);
      i_tvalid = {!done3, (idx2 < 3) && !drop, 2'b00};
      i_tdata  = {8'h30, 8'(8'h20 + idx2), 16'h0000};
      i_tlast  = {1'b1, idx2 == 2, 2'b00};
      #1;
      if (idx2 < 3) chk("drop_tready3", {31'd0, o_tready[3]}, 32'd0);
      if (drop) begin
        chk("drop_grant", {30'd0, o_grant}, 32'd2);
        chk("drop_busy", {31'd0, o_busy}, 32'd1);
        dropc++;
      end
      if (o_tvalid) begin
        chk("drop_data", {24'd0, o_tdata}, {24'd0, exp4[nout]});
        nout++;
      end
      hs = i_tvalid & o_tready;
      @(negedge clk);
      if (hs[2]) idx2++;
      if (hs[3]) done3 = 1'b1;
    end
    chk("drop_count", 32'(nout), 32'd4);
    chk("drop_cycles", 32'(dropc), 32'd5);
    chk("drop_grant_final", {30'd0, o_grant}, 32'd3);

    // asynchronous reset in the middle of a 10-beat packet
    do_reset();
    idx0 = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      i_tvalid = 4'b0011;
      i_tdata  = {16'h0000, 8'h99, 8'(8'h80 + idx0)};
      i_tlast  = {3'b000, idx0 == 9};
      #1;
      hs = i_tvalid & o_tready;
      if (idx0 == 4) begin
        chk("mrst_pre_tvalid", {31'd0, o_tvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("mrst_busy", {31'd0, o_busy}, 32'd0);
        chk("mrst_tready", {28'd0, o_tready}, 32'd0);
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (hs[0]) idx0++;
      end
    end
    chk("mrst_reached", {31'd0, done}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_grant_rel", {30'd0, o_grant}, 32'd3);
    chk("mrst_tvalid_rel", {31'd0, o_tvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mrst_first_grant", {30'd0, o_grant}, 32'd0);
    chk("mrst_first_busy", {31'd0, o_busy}, 32'd1);

    // randomised valid/ready with per-source sequence scoreboard
    do_reset();
    vld_r = '0; in_pkt = 1'b0; cur_src = '0;
    for (int k = 0; k < 4; k++) begin
      rem[k] = 0; seq[k] = '0; exp_seq[k] = '0; waitc[k] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) rand_cycle(1'b1);
    done = 1'b0;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      rand_cycle(1'b0);
      done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0) && !o_tvalid;
    end
    chk("rand_drained", {31'd0, done}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rand_total%0d", k), {26'd0, exp_seq[k]}, {26'd0, seq[k]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
